// File: rtl/alu_agent_pkg.sv
// Shared types for the ALU agent: opcodes, widths and the request/tag/response records.
// Used by alu_issue_ctrl (optional stats build: define ALU_ISSUE_STATS_EN).
package alu_agent_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_TXN_W  = 32;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_type_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] val1;
        logic [ALU_DATA_W-1:0] val2;
        op_type_t              mode;
        logic [ALU_TXN_W-1:0]  txn_id;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_TXN_W-1:0] txn_id;
        logic                 err;
    } alu_tag_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [ALU_TXN_W-1:0]  txn_id;
        logic                  err;
    } alu_rsp_t;

    function automatic logic isDivZero(input alu_req_t r);
        return (r.mode == DIV) && (r.val2 == '0);
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Show-ahead synchronous FIFO of arbitrary element type; pushes while full are ignored.
module alu_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU front end: buffers tagged requests, issues under a credit limit, re-tags results in order.
// Define ALU_ISSUE_STATS_EN to add the saturating stat_* counters.
module alu_issue_ctrl
    import alu_agent_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ALU_DATA_W-1:0] req_val1,
    input  logic [ALU_DATA_W-1:0] req_val2,
    input  op_type_t              req_mode,
    input  logic [ALU_TXN_W-1:0]  req_txn_id,
    output logic                  alu_valid_i,
    output logic [ALU_DATA_W-1:0] alu_val1,
    output logic [ALU_DATA_W-1:0] alu_val2,
    output op_type_t              alu_mode,
    input  logic                  alu_valid_o,
    input  logic [ALU_DATA_W-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ALU_DATA_W-1:0] rsp_result,
    output logic [ALU_TXN_W-1:0]  rsp_txn_id,
    output logic                  rsp_err,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_div0,
    output logic [31:0]           stat_credit_stall,
`endif
    output logic                  err_spurious
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    alu_req_t              reqIn, reqHead;
    alu_tag_t              tagIn, tagHead;
    alu_rsp_t              rspIn, rspHead;
    logic                  reqPush, reqEmpty, reqFull;
    logic                  tagEmpty, tagFull, tagPop;
    logic                  rspEmpty, rspFull, rspPop;
    logic                  issue, headDiv0, retValid;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  mask_q, spurious_q, aluValid_q;
    logic [ALU_DATA_W-1:0] aluVal1_q, aluVal2_q;
    op_type_t              aluMode_q;

    assign reqIn     = '{val1: req_val1, val2: req_val2, mode: req_mode, txn_id: req_txn_id};
    assign req_ready = !rst && !reqFull;
    assign reqPush   = req_valid && req_ready;

    assign headDiv0 = isDivZero(reqHead);
    assign issue    = !reqEmpty && (credits_q != '0) && !tagFull;
    assign tagIn    = '{txn_id: reqHead.txn_id, err: headDiv0};

    // Results arriving during reset or on the first edge after it belong to discarded work.
    assign retValid = alu_valid_o && !mask_q;
    assign tagPop   = retValid && !tagEmpty && !rspFull;
    assign rspIn    = '{result: (tagHead.err ? '0 : alu_result), txn_id: tagHead.txn_id, err: tagHead.err};

    assign rsp_valid  = !rspEmpty;
    assign rspPop     = rsp_valid && rsp_ready;
    assign rsp_result = rspEmpty ? '0 : rspHead.result;
    assign rsp_txn_id = rspEmpty ? '0 : rspHead.txn_id;
    assign rsp_err    = !rspEmpty && rspHead.err;

    assign alu_valid_i  = aluValid_q;
    assign alu_val1     = aluVal1_q;
    assign alu_val2     = aluVal2_q;
    assign alu_mode     = aluMode_q;
    assign err_spurious = spurious_q;

    alu_sync_fifo #(.T(alu_req_t), .DEPTH(REQ_DEPTH)) u_reqFifo (
        .clk(clk), .rst(rst), .push_i(reqPush), .data_i(reqIn), .pop_i(issue),
        .data_o(reqHead), .empty_o(reqEmpty), .full_o(reqFull)
    );

    alu_sync_fifo #(.T(alu_tag_t), .DEPTH(RSP_DEPTH)) u_tagFifo (
        .clk(clk), .rst(rst), .push_i(issue), .data_i(tagIn), .pop_i(tagPop),
        .data_o(tagHead), .empty_o(tagEmpty), .full_o(tagFull)
    );

    alu_sync_fifo #(.T(alu_rsp_t), .DEPTH(RSP_DEPTH)) u_rspFifo (
        .clk(clk), .rst(rst), .push_i(tagPop), .data_i(rspIn), .pop_i(rspPop),
        .data_o(rspHead), .empty_o(rspEmpty), .full_o(rspFull)
    );

    always_comb begin
        credits_d = credits_q;
        if (issue && !rspPop)      credits_d = credits_q - 1'b1;
        else if (!issue && rspPop) credits_d = credits_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= CW'(RSP_DEPTH);
            mask_q     <= 1'b1;
            spurious_q <= 1'b0;
            aluValid_q <= 1'b0;
            aluVal1_q  <= '0;
            aluVal2_q  <= '0;
            aluMode_q  <= ADD;
        end else begin
            credits_q  <= credits_d;
            mask_q     <= 1'b0;
            aluValid_q <= issue;
            if (retValid && tagEmpty) spurious_q <= 1'b1;
            // A zero divisor is still issued to keep ordering, with a harmless divisor of 1.
            if (issue) begin
                aluVal1_q <= reqHead.val1;
                aluVal2_q <= headDiv0 ? ALU_DATA_W'(1) : reqHead.val2;
                aluMode_q <= reqHead.mode;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] statIssued_q, statDiv0_q, statStall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statIssued_q <= '0;
            statDiv0_q   <= '0;
            statStall_q  <= '0;
        end else begin
            if (issue && statIssued_q != '1)             statIssued_q <= statIssued_q + 1'b1;
            if (issue && headDiv0 && statDiv0_q != '1)   statDiv0_q   <= statDiv0_q + 1'b1;
            if (!reqEmpty && credits_q == '0 && statStall_q != '1) statStall_q <= statStall_q + 1'b1;
        end
    end

    assign stat_issued       = statIssued_q;
    assign stat_div0         = statDiv0_q;
    assign stat_credit_stall = statStall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a one-cycle registered ALU model.
module tb_alu_issue_ctrl;
    import alu_agent_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_val1 = '0;
    logic [15:0] req_val2 = '0;
    op_type_t    req_mode = ADD;
    logic [31:0] req_txn_id = '0;
    logic        alu_valid_i;
    logic [15:0] alu_val1, alu_val2;
    op_type_t    alu_mode;
    logic        alu_valid_o;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [31:0] rsp_txn_id;
    logic        rsp_err;
    logic        err_spurious;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_issued, stat_div0, stat_credit_stall;
`endif

    int          nCompared = 0;
    int          nMismatched = 0;
    int          issueCnt = 0;
    logic        aluValidQ = 1'b0;
    logic        forceValid = 1'b0;
    logic [15:0] aluResQ = '0;
    alu_rsp_t    gotQ[$];

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_val1(req_val1), .req_val2(req_val2),
        .req_mode(req_mode), .req_txn_id(req_txn_id),
        .alu_valid_i(alu_valid_i), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_mode(alu_mode),
        .alu_valid_o(alu_valid_o), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_txn_id(rsp_txn_id), .rsp_err(rsp_err),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued(stat_issued), .stat_div0(stat_div0), .stat_credit_stall(stat_credit_stall),
`endif
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // ALU stand-in: registers its result one cycle after the issue strobe, never reset.
    always @(posedge clk) begin
        aluValidQ <= alu_valid_i;
        case (alu_mode)
            ADD:     aluResQ <= alu_val1 + alu_val2;
            SUB:     aluResQ <= alu_val1 - alu_val2;
            MUL:     aluResQ <= alu_val1 * alu_val2;
            default: aluResQ <= (alu_val2 == 16'd0) ? 16'hFFFF : alu_val1 / alu_val2;
        endcase
        if (alu_valid_i === 1'b1) issueCnt <= issueCnt + 1;
    end

    assign alu_valid_o = aluValidQ | forceValid;
    assign alu_result  = aluResQ;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic [15:0] v1, input logic [15:0] v2, input op_type_t m, input logic [31:0] id);
        int waitCnt = 0;
        req_valid = 1'b1; req_val1 = v1; req_val2 = v2; req_mode = m; req_txn_id = id;
        while (!req_ready && waitCnt < 50) begin tick(); waitCnt++; end
        if (waitCnt == 50) begin
            nCompared++; nMismatched++;
            $display("[TB] FAIL send_timeout: req_ready got %0b required 1 for txn %0h", req_ready, id);
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Records handshaken responses; rsp_ready must already be high.
    task automatic captureResponses(input int n, input int budget);
        gotQ.delete();
        for (int c = 0; c < budget && gotQ.size() < n; c++) begin
            if (rsp_valid && rsp_ready) gotQ.push_back('{result: rsp_result, txn_id: rsp_txn_id, err: rsp_err});
            tick();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req_ready: got %0b required 0", req_ready); end
        nCompared++; if (alu_valid_i !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_alu_valid: got %0b required 0", alu_valid_i); end
        nCompared++; if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
        nCompared++; if (err_spurious !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_spurious: got %0b required 0", err_spurious); end
        rst = 1'b0;
        #1;
        nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_release_ready: got %0b required 1", req_ready); end
        tick();
    endtask

    task automatic test_add_latency();
        rsp_ready = 1'b1;
        sendReq(16'd3, 16'd4, ADD, 32'h10);
        nCompared++; if (alu_valid_i !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_issue_early: got %0b required 0", alu_valid_i); end
        tick();
        nCompared++; if (alu_valid_i !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_issue: got %0b required 1", alu_valid_i); end
        nCompared++; if (alu_val1 !== 16'd3 || alu_val2 !== 16'd4 || alu_mode !== ADD) begin nMismatched++; $display("[TB] FAIL add_operands: got %0d,%0d,%0d required 3,4,0", alu_val1, alu_val2, alu_mode); end
        tick();
        nCompared++; if (alu_valid_i !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_single_issue: got %0b required 0", alu_valid_i); end
        nCompared++; if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_rsp_early: got %0b required 0", rsp_valid); end
        tick();
        nCompared++; if (rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_rsp_valid: got %0b required 1", rsp_valid); end
        nCompared++; if (rsp_result !== 16'd7 || rsp_txn_id !== 32'h10 || rsp_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_rsp: got %0h/%0h/%0b required 7/10/0", rsp_result, rsp_txn_id, rsp_err); end
        tick();
        nCompared++; if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_rsp_popped: got %0b required 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expRes [3];
        expRes[0] = 16'd7; expRes[1] = 16'h5F90; expRes[2] = 16'd4;
        rsp_ready = 1'b1;
        sendReq(16'd10, 16'd3, SUB, 32'h1);
        sendReq(16'd300, 16'd300, MUL, 32'h2);
        nCompared++; if (alu_valid_i !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_issue0: got %0b required 1", alu_valid_i); end
        sendReq(16'd9, 16'd2, DIV, 32'h3);
        nCompared++; if (alu_valid_i !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_issue1: got %0b required 1", alu_valid_i); end
        tick();
        nCompared++; if (alu_valid_i !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_issue2: got %0b required 1", alu_valid_i); end
        captureResponses(3, 20);
        nCompared++; if (gotQ.size() != 3) begin nMismatched++; $display("[TB] FAIL b2b_count: got %0d required 3", gotQ.size()); end
        for (int i = 0; i < gotQ.size() && i < 3; i++) begin
            nCompared++;
            if (gotQ[i].result !== expRes[i] || gotQ[i].txn_id !== 32'(i + 1) || gotQ[i].err !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL b2b_rsp%0d: got %0h/%0h/%0b required %0h/%0h/0", i, gotQ[i].result, gotQ[i].txn_id, gotQ[i].err, expRes[i], i + 1);
            end
        end
        nCompared++; if (alu_valid_i !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_idle: got %0b required 0", alu_valid_i); end
    endtask

    task automatic test_div_zero();
        rsp_ready = 1'b1;
        sendReq(16'd5, 16'd0, DIV, 32'hAB);
        tick();
        nCompared++; if (alu_valid_i !== 1'b1 || alu_val2 !== 16'd1) begin nMismatched++; $display("[TB] FAIL div0_issue: got valid %0b val2 %0d required 1/1", alu_valid_i, alu_val2); end
        captureResponses(1, 20);
        nCompared++; if (gotQ.size() != 1) begin nMismatched++; $display("[TB] FAIL div0_count: got %0d required 1", gotQ.size()); end
        else begin
            nCompared++;
            if (gotQ[0].result !== 16'd0 || gotQ[0].txn_id !== 32'hAB || gotQ[0].err !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL div0_rsp: got %0h/%0h/%0b required 0/ab/1", gotQ[0].result, gotQ[0].txn_id, gotQ[0].err);
            end
        end
    endtask

    task automatic test_credit_limit();
        int base;
        rsp_ready = 1'b0;
        base = issueCnt;
        for (int i = 0; i < 8; i++) sendReq(16'(i * 5 + 1), 16'(i), ADD, 32'h100 + 32'(i));
        nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL credit_req_full: got %0b required 0", req_ready); end
        repeat (6) tick();
        nCompared++; if (issueCnt - base != 4) begin nMismatched++; $display("[TB] FAIL credit_issues: got %0d required 4", issueCnt - base); end
        nCompared++; if (alu_valid_i !== 1'b0) begin nMismatched++; $display("[TB] FAIL credit_stalled: got %0b required 0", alu_valid_i); end
        nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL credit_still_full: got %0b required 0", req_ready); end
        nCompared++; if (rsp_valid !== 1'b1 || rsp_txn_id !== 32'h100) begin nMismatched++; $display("[TB] FAIL credit_head: got %0b/%0h required 1/100", rsp_valid, rsp_txn_id); end
        rsp_ready = 1'b1;
        captureResponses(8, 80);
        nCompared++; if (gotQ.size() != 8) begin nMismatched++; $display("[TB] FAIL credit_drain_count: got %0d required 8", gotQ.size()); end
        for (int i = 0; i < gotQ.size() && i < 8; i++) begin
            nCompared++;
            if (gotQ[i].result !== 16'(6 * i + 1) || gotQ[i].txn_id !== 32'h100 + 32'(i) || gotQ[i].err !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL credit_rsp%0d: got %0h/%0h/%0b required %0h/%0h/0", i, gotQ[i].result, gotQ[i].txn_id, gotQ[i].err, 6 * i + 1, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        sendReq(16'd100, 16'd1, ADD, 32'h20);
        sendReq(16'd200, 16'd2, ADD, 32'h21);
        tick();
        // ALU now holds a result for the first op and the second is being issued.
        rst = 1'b1;
        #1;
        nCompared++; if (alu_valid_i !== 1'b0 || alu_val1 !== 16'd0 || alu_val2 !== 16'd0 || alu_mode !== ADD) begin nMismatched++; $display("[TB] FAIL mid_rst_alu: got %0b/%0h/%0h/%0d required all 0", alu_valid_i, alu_val1, alu_val2, alu_mode); end
        nCompared++; if (rsp_valid !== 1'b0 || rsp_result !== 16'd0 || rsp_txn_id !== 32'd0 || rsp_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_rsp: got %0b/%0h/%0h/%0b required all 0", rsp_valid, rsp_result, rsp_txn_id, rsp_err); end
        nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_ready: got %0b required 0", req_ready); end
        rst = 1'b0;
        tick();
        nCompared++; if (err_spurious !== 1'b0 || rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_stale: got spurious %0b rsp_valid %0b required 0/0", err_spurious, rsp_valid); end
        repeat (3) tick();
        nCompared++; if (err_spurious !== 1'b0 || rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_quiet: got spurious %0b rsp_valid %0b required 0/0", err_spurious, rsp_valid); end
        sendReq(16'd1, 16'd1, ADD, 32'h30);
        captureResponses(1, 20);
        nCompared++; if (gotQ.size() != 1) begin nMismatched++; $display("[TB] FAIL mid_rst_after_count: got %0d required 1", gotQ.size()); end
        else begin
            nCompared++;
            if (gotQ[0].result !== 16'd2 || gotQ[0].txn_id !== 32'h30) begin
                nMismatched++;
                $display("[TB] FAIL mid_rst_after_rsp: got %0h/%0h required 2/30", gotQ[0].result, gotQ[0].txn_id);
            end
        end
    endtask

    task automatic test_spurious();
        rsp_ready = 1'b1;
        forceValid = 1'b1;
        tick();
        forceValid = 1'b0;
        nCompared++; if (err_spurious !== 1'b1) begin nMismatched++; $display("[TB] FAIL spur_set: got %0b required 1", err_spurious); end
        nCompared++; if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL spur_no_rsp: got %0b required 0", rsp_valid); end
        repeat (4) tick();
        nCompared++; if (err_spurious !== 1'b1) begin nMismatched++; $display("[TB] FAIL spur_sticky: got %0b required 1", err_spurious); end
        rst = 1'b1;
        #1;
        nCompared++; if (err_spurious !== 1'b0) begin nMismatched++; $display("[TB] FAIL spur_cleared: got %0b required 0", err_spurious); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_div_zero();
        test_credit_limit();
        test_reset_midflight();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Request-side front end that sits directly upstream of the ALU datapath.
- Accepts operand/opcode/transaction-ID requests on a valid/ready interface and buffers them.
- Drives the ALU one operation per cycle under a credit limit, then pairs each ALU result, in order, with its transaction ID.
- Returns tagged responses on a valid/ready interface. The ALU has no ID, error or back-pressure path; this block supplies all three.

Parameters:
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2).
- RSP_DEPTH, 4, response FIFO entries; also the maximum number of issued-but-unreturned operations (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_val1  in  16  operand 1 (unsigned).
- req_val2  in  16  operand 2 (unsigned).
- req_mode  in  op_type_t  ADD/SUB/MUL/DIV.
- req_txn_id  in  32  transaction ID.
- alu_valid_i  out  1  issue strobe to ALU.
- alu_val1  out  16  operand 1 to ALU.
- alu_val2  out  16  operand 2 to ALU.
- alu_mode  out  op_type_t  opcode to ALU.
- alu_valid_o  in  1  ALU result valid.
- alu_result  in  16  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_result  out  16  result (0 on error).
- rsp_txn_id  out  32  transaction ID of the response.
- rsp_err  out  1  divide-by-zero flag.
- err_spurious  out  1  sticky: ALU result arrived with no outstanding tag.

Behaviour:
- Reset:
  - Asserting rst immediately empties both FIFOs and the tag FIFO and sets credits=RSP_DEPTH.
  - All outputs go to 0, except req_ready=1 once rst is low.
  - Reset mid-operation discards every queued and in-flight item with no response.
  - alu_valid_o is ignored while rst is high and on the first clk edge after release, which absorbs a stale ALU strobe.
- Request FIFO:
  - req_ready = !req_full. There is no full-bypass: a pop and a push in the same cycle while full is not accepted.
- Issue, registered:
  - Issue occurs at an edge where the request FIFO is non-empty and credits>0.
  - That edge pops the head, sets alu_valid_i=1 and alu_val1/val2/mode from the head, pushes tag {txn_id, err} to the tag FIFO (depth RSP_DEPTH), and decrements credits.
  - At an edge with no issue, alu_valid_i=0 and the alu_* data outputs hold their previous values.
  - Maximum throughput is one issue per cycle.
- Divide by zero:
  - Applies when mode==DIV and val2==0.
  - The operation is still issued to preserve ordering, but alu_val2 is forced to 1 and the tag has err=1.
  - The response carries rsp_result=0 and rsp_err=1.
- Return path:
  - At an edge with alu_valid_o=1 (not masked): pop the tag and push {err?0:alu_result, txn_id, err} into the response FIFO.
  - If the tag FIFO is empty, drop the result and set err_spurious, which stays set until rst.
- Response FIFO:
  - Show-ahead: rsp_* present the head; rsp_valid = !rsp_empty.
  - A handshake pops the head and increments credits.
  - Push and pop may occur in the same cycle.
  - Credits guarantee the response FIFO never overflows, since the ALU cannot stall.
  - Credits = RSP_DEPTH minus (tags outstanding + responses held). If issue and response pop occur in the same cycle, credits are unchanged.
- Latency with an idle ALU, where the ALU registers its result one cycle after valid_i:
  - Request accepted at edge N.
  - alu_valid_i high after edge N+1.
  - alu_valid_o sampled at edge N+3.
  - rsp_valid high after edge N+3.
  - Responses are always returned in request order.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, adds outputs stat_issued (32), stat_div0 (32) and stat_credit_stall (32).
  - stat_issued counts issues.
  - stat_div0 counts divide-by-zero issues.
  - stat_credit_stall counts cycles where the request FIFO is non-empty but credits==0.
  - All three saturate at all-ones and clear on rst.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_agent_pkg holds:
  - op_type_t (already shared).
  - ALU_DATA_W=16 and ALU_TXN_W=32.
  - Packed structs alu_req_t {val1, val2, mode, txn_id}, alu_tag_t {txn_id, err} and alu_rsp_t {result, txn_id, err}.
- One natural sub-module: alu_sync_fifo, parameterised on element type and depth, with asynchronous reset.
  - It is instantiated three times: request, tag and response FIFOs.

Test Plan:
- ADD 3+4, txn 0x10, rsp_ready=1 -> rsp_valid after edge N+3 with rsp_result=7, rsp_txn_id=0x10, rsp_err=0.
- Back-to-back SUB 10-3 (0x1), MUL 300*300 (0x2), DIV 9/2 (0x3) -> responses in order 7, 0x5F90 (90000 mod 2^16), 4; alu_valid_i high on 3 consecutive cycles.
- DIV 5/0, txn 0xAB -> alu_val2=1 at issue; response rsp_result=0, rsp_err=1, rsp_txn_id=0xAB.
- rsp_ready=0 with 8 requests (defaults) -> exactly 4 issues, then alu_valid_i stays 0; req_ready falls after 4 more are queued; releasing rsp_ready drains all 8 in order.
- rst pulsed while 2 operations are in flight -> all outputs 0, no responses, err_spurious=0; a subsequent ADD 1+1 returns 2.
- Forcing alu_valid_o=1 with no issue outstanding -> err_spurious=1, sticky until rst; no response pushed.
